// File: rtl/bus_connect_pkg.sv
// -----------------------------------------------------------------------------
// bus_connect_pkg
// Shared definitions for the bus-connect block: FSM state encoding, the
// default DM wait-state timeout and the timeout-counter width helper.
// -----------------------------------------------------------------------------
package bus_connect_pkg;

    typedef enum logic [1:0] {
        BC_IDLE = 2'd0,
        BC_REQ  = 2'd1,
        BC_DONE = 2'd2
    } bc_state_t;

    localparam int BC_TIMEOUT_DEFAULT = 15;

    // Wide enough to hold the value TIMEOUT itself.
    function automatic int bc_ctr_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int BC_CTR_W_DEFAULT = $clog2(BC_TIMEOUT_DEFAULT + 1);

endpackage

// File: rtl/bus_connect_timeout_ctr.sv
// -----------------------------------------------------------------------------
// bc_timeout_ctr
// Loadable, clearable, saturating up-counter with a terminal flag. Used by
// bus_connect to bound the number of cycles spent waiting for a DM ack.
//
// Ports:
//   clk       system clock
//   reset     asynchronous active-high reset (count -> 0)
//   clr       synchronous clear (highest priority after reset)
//   load      synchronous load of load_val
//   load_val  value loaded when load is high
//   inc       increment request (ignored once count reaches TERM)
//   term      high while the current cycle is the TERM-th counted cycle,
//             i.e. count >= TERM-1
// -----------------------------------------------------------------------------
module bc_timeout_ctr #(
    parameter int W    = 4,
    parameter int TERM = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic         term
);

    localparam logic [W-1:0] SAT     = W'(TERM);
    localparam logic [W-1:0] TERM_M1 = W'(TERM - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && (count != SAT)) begin
            count <= count + 1'b1;
        end
    end

    // The count holds the number of completed wait cycles, so the cycle in
    // which it equals TERM-1 is the last one allowed.
    assign term = (count >= TERM_M1);

endmodule

// File: rtl/bus_connect.sv
// -----------------------------------------------------------------------------
// bus_connect
// Bridges the compute unit and data memory for loads, stores and immediate
// loads issued by the program sequencer. Drives bc_dt toward the crossbar,
// takes store data from crossbar X-port, and runs a req/ack handshake to DM
// with a wait-state timeout. PS is stalled while a DM transfer is pending.
//
// State table:
//   BC_IDLE | waiting for a PS request; immediates handled here
//   BC_REQ  | bc_dm_req high, waiting for dm_bc_ack or timeout
//   BC_DONE | load data on bc_dt, bc_ps_dt_vld high for this cycle
//
// Ports:
//   clk, reset                    clock, async active-high reset
//   ps_bc_dm_rd / ps_bc_dm_wr     load / store request from PS
//   ps_bc_dm_add                  transfer address
//   ps_bc_imm_en / ps_bc_imm      immediate-load request and value
//   xb_dtx                        crossbar X-port data (store data)
//   bc_dm_req/we/add/wdt          DM request, direction, address, write data
//   dm_bc_rdt / dm_bc_ack         DM read data and single-cycle acknowledge
//   bc_dt                         data to crossbar (holds last value)
//   bc_ps_dt_vld                  one-cycle pulse: bc_dt has new data
//   bc_ps_stall                   high while a DM transfer is outstanding
//   bc_ps_err                     one-cycle error pulse (conflict / timeout)
// -----------------------------------------------------------------------------
module bus_connect
    import bus_connect_pkg::*;
#(
    parameter int RF_DATASIZE   = 16,
    parameter int DM_ADDR_WIDTH = 16,
    parameter int TIMEOUT       = BC_TIMEOUT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ps_bc_dm_rd,
    input  logic                     ps_bc_dm_wr,
    input  logic [DM_ADDR_WIDTH-1:0] ps_bc_dm_add,
    input  logic                     ps_bc_imm_en,
    input  logic [RF_DATASIZE-1:0]   ps_bc_imm,
    input  logic [RF_DATASIZE-1:0]   xb_dtx,
    output logic                     bc_dm_req,
    output logic                     bc_dm_we,
    output logic [DM_ADDR_WIDTH-1:0] bc_dm_add,
    output logic [RF_DATASIZE-1:0]   bc_dm_wdt,
    input  logic [RF_DATASIZE-1:0]   dm_bc_rdt,
    input  logic                     dm_bc_ack,
    output logic [RF_DATASIZE-1:0]   bc_dt,
    output logic                     bc_ps_dt_vld,
    output logic                     bc_ps_stall,
    output logic                     bc_ps_err
);

    localparam int CTR_W = bc_ctr_width(TIMEOUT);

    bc_state_t state;
    logic      in_req;
    logic      ctr_inc;
    logic      ctr_clr;
    logic      ctr_term;

    assign in_req  = (state == BC_REQ);
    // Count only unacknowledged REQ cycles; clear when the REQ phase ends.
    assign ctr_inc = in_req && !dm_bc_ack && !ctr_term;
    assign ctr_clr = in_req && (dm_bc_ack || ctr_term);

    bc_timeout_ctr #(
        .W    (CTR_W),
        .TERM (TIMEOUT)
    ) u_timeout_ctr (
        .clk      (clk),
        .reset    (reset),
        .clr      (ctr_clr),
        .load     (1'b0),
        .load_val ({CTR_W{1'b0}}),
        .inc      (ctr_inc),
        .term     (ctr_term)
    );

    assign bc_ps_stall = (state != BC_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= BC_IDLE;
            bc_dm_req    <= 1'b0;
            bc_dm_we     <= 1'b0;
            bc_dm_add    <= '0;
            bc_dm_wdt    <= '0;
            bc_dt        <= '0;
            bc_ps_dt_vld <= 1'b0;
            bc_ps_err    <= 1'b0;
        end else begin
            bc_ps_dt_vld <= 1'b0;
            bc_ps_err    <= 1'b0;
            case (state)
                BC_IDLE: begin
                    // A memory request always beats a concurrent immediate.
                    if (ps_bc_dm_rd && ps_bc_dm_wr) begin
                        bc_ps_err <= 1'b1;
                    end else if (ps_bc_dm_rd) begin
                        bc_dm_add <= ps_bc_dm_add;
                        bc_dm_we  <= 1'b0;
                        bc_dm_req <= 1'b1;
                        state     <= BC_REQ;
                    end else if (ps_bc_dm_wr) begin
                        bc_dm_add <= ps_bc_dm_add;
                        bc_dm_wdt <= xb_dtx;
                        bc_dm_we  <= 1'b1;
                        bc_dm_req <= 1'b1;
                        state     <= BC_REQ;
                    end else if (ps_bc_imm_en) begin
                        bc_dt        <= ps_bc_imm;
                        bc_ps_dt_vld <= 1'b1;
                    end
                end
                BC_REQ: begin
                    if (dm_bc_ack) begin
                        bc_dm_req <= 1'b0;
                        if (!bc_dm_we) begin
                            bc_dt        <= dm_bc_rdt;
                            bc_ps_dt_vld <= 1'b1;
                            state        <= BC_DONE;
                        end else begin
                            state <= BC_IDLE;
                        end
                    end else if (ctr_term) begin
                        bc_dm_req <= 1'b0;
                        bc_ps_err <= 1'b1;
                        state     <= BC_IDLE;
                    end
                end
                BC_DONE: begin
                    state <= BC_IDLE;
                end
                default: begin
                    state     <= BC_IDLE;
                    bc_dm_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_connect.sv
module tb_bus_connect;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int TO = 15;

    localparam int K_RD     = 0;
    localparam int K_WR     = 1;
    localparam int K_IMM    = 2;
    localparam int K_CONF   = 3;
    localparam int K_RD_IMM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ps_bc_dm_rd;
    logic          ps_bc_dm_wr;
    logic [AW-1:0] ps_bc_dm_add;
    logic          ps_bc_imm_en;
    logic [DW-1:0] ps_bc_imm;
    logic [DW-1:0] xb_dtx;
    logic          bc_dm_req;
    logic          bc_dm_we;
    logic [AW-1:0] bc_dm_add;
    logic [DW-1:0] bc_dm_wdt;
    logic [DW-1:0] dm_bc_rdt;
    logic          dm_bc_ack;
    logic [DW-1:0] bc_dt;
    logic          bc_ps_dt_vld;
    logic          bc_ps_stall;
    logic          bc_ps_err;

    always #5 clk = ~clk;

    bus_connect #(
        .RF_DATASIZE   (DW),
        .DM_ADDR_WIDTH (AW),
        .TIMEOUT       (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ps_bc_dm_rd  (ps_bc_dm_rd),
        .ps_bc_dm_wr  (ps_bc_dm_wr),
        .ps_bc_dm_add (ps_bc_dm_add),
        .ps_bc_imm_en (ps_bc_imm_en),
        .ps_bc_imm    (ps_bc_imm),
        .xb_dtx       (xb_dtx),
        .bc_dm_req    (bc_dm_req),
        .bc_dm_we     (bc_dm_we),
        .bc_dm_add    (bc_dm_add),
        .bc_dm_wdt    (bc_dm_wdt),
        .dm_bc_rdt    (dm_bc_rdt),
        .dm_bc_ack    (dm_bc_ack),
        .bc_dt        (bc_dt),
        .bc_ps_dt_vld (bc_ps_dt_vld),
        .bc_ps_stall  (bc_ps_stall),
        .bc_ps_err    (bc_ps_err)
    );

    int checks   = 0;
    int failures = 0;

    // Reference copy of what bc_dt should currently hold.
    logic [DW-1:0] exp_dt;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic ps_idle();
        ps_bc_dm_rd  = 1'b0;
        ps_bc_dm_wr  = 1'b0;
        ps_bc_imm_en = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk_val({tag, "_req"},   32'(bc_dm_req),    32'd0);
        chk_val({tag, "_we"},    32'(bc_dm_we),     32'd0);
        chk_val({tag, "_add"},   32'(bc_dm_add),    32'd0);
        chk_val({tag, "_wdt"},   32'(bc_dm_wdt),    32'd0);
        chk_val({tag, "_dt"},    32'(bc_dt),        32'd0);
        chk_val({tag, "_vld"},   32'(bc_ps_dt_vld), 32'd0);
        chk_val({tag, "_stall"}, 32'(bc_ps_stall),  32'd0);
        chk_val({tag, "_err"},   32'(bc_ps_err),    32'd0);
    endtask

    // One PS transaction. Called one time unit after a rising edge. DM acks
    // during REQ cycle (waits+1), or never if that exceeds the timeout.
    // Observes a fixed window of cycles and compares cycle counts against
    // the transaction-level expectations.
    task automatic run_txn(input string tag, input int kind, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [DW-1:0] imm, input int waits);
        int req_n = 0, stall_n = 0, vld_n = 0, vld_at = 0, err_n = 0, err_at = 0;
        int exp_req, exp_stall, exp_vld, exp_vld_at, exp_err, exp_err_at;
        logic [AW-1:0] add1 = '0;
        logic          we1  = 1'b0;
        logic [DW-1:0] wdt1 = '0;
        bit is_mem, is_rd, acked;

        ps_bc_dm_rd  = (kind == K_RD) || (kind == K_CONF) || (kind == K_RD_IMM);
        ps_bc_dm_wr  = (kind == K_WR) || (kind == K_CONF);
        ps_bc_imm_en = (kind == K_IMM) || (kind == K_RD_IMM);
        ps_bc_dm_add = addr;
        xb_dtx       = data;
        ps_bc_imm    = imm;
        dm_bc_ack    = 1'b0;
        dm_bc_rdt    = DW'($urandom);

        is_mem = (kind == K_RD) || (kind == K_WR) || (kind == K_RD_IMM);
        is_rd  = (kind != K_WR);

        for (int c = 1; c <= TO + 4; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                add1 = bc_dm_add;
                we1  = bc_dm_we;
                wdt1 = bc_dm_wdt;
            end
            if (bc_dm_req)   req_n++;
            if (bc_ps_stall) stall_n++;
            if (bc_ps_dt_vld) begin
                vld_n++;
                if (vld_at == 0) vld_at = c;
            end
            if (bc_ps_err) begin
                err_n++;
                if (err_at == 0) err_at = c;
            end
            if (!bc_ps_stall) ps_idle();
            if (is_mem) begin
                dm_bc_ack = (c == waits + 1);
                dm_bc_rdt = (c == waits + 1) ? data : DW'($urandom);
            end else begin
                // Stray acks while idle must be ignored.
                dm_bc_ack = 1'($urandom_range(0, 1));
                dm_bc_rdt = DW'($urandom);
            end
        end
        dm_bc_ack = 1'b0;
        ps_idle();

        acked      = (waits + 1 <= TO);
        exp_req    = 0;
        exp_stall  = 0;
        exp_vld    = 0;
        exp_vld_at = 0;
        exp_err    = 0;
        exp_err_at = 0;
        if (is_mem && acked) begin
            exp_req   = waits + 1;
            exp_stall = waits + 1 + (is_rd ? 1 : 0);
            if (is_rd) begin
                exp_vld    = 1;
                exp_vld_at = waits + 2;
                exp_dt     = data;
            end
        end else if (is_mem) begin
            exp_req    = TO;
            exp_stall  = TO;
            exp_err    = 1;
            exp_err_at = TO + 1;
        end else if (kind == K_IMM) begin
            exp_vld    = 1;
            exp_vld_at = 1;
            exp_dt     = imm;
        end else begin
            exp_err    = 1;
            exp_err_at = 1;
        end

        chk_val({tag, "_req_cycles"},   32'(req_n),   32'(exp_req));
        chk_val({tag, "_stall_cycles"}, 32'(stall_n), 32'(exp_stall));
        chk_val({tag, "_vld_pulses"},   32'(vld_n),   32'(exp_vld));
        chk_val({tag, "_err_pulses"},   32'(err_n),   32'(exp_err));
        chk_val({tag, "_bc_dt"},        32'(bc_dt),   32'(exp_dt));
        if (exp_vld != 0) chk_val({tag, "_vld_cycle"}, 32'(vld_at), 32'(exp_vld_at));
        if (exp_err != 0) chk_val({tag, "_err_cycle"}, 32'(err_at), 32'(exp_err_at));
        if (is_mem) begin
            chk_val({tag, "_dm_add"}, 32'(add1), 32'(addr));
            chk_val({tag, "_dm_we"},  32'(we1),  32'(!is_rd));
            if (!is_rd) chk_val({tag, "_dm_wdt"}, 32'(wdt1), 32'(data));
        end
    endtask

    initial begin
        reset        = 1'b1;
        ps_idle();
        ps_bc_dm_add = '0;
        ps_bc_imm    = '0;
        xb_dtx       = '0;
        dm_bc_rdt    = '0;
        dm_bc_ack    = 1'b0;
        exp_dt       = '0;

        #2;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_txn("load_3ws",  K_RD,     16'h0040, 16'hBEEF, 16'h0000, 3);
        run_txn("store",     K_WR,     16'h0102, 16'h1234, 16'h0000, 0);
        run_txn("imm",       K_IMM,    16'h0000, 16'h0000, 16'h00FF, 0);
        run_txn("timeout",   K_RD,     16'h0200, 16'hDEAD, 16'h0000, 40);
        run_txn("conflict",  K_CONF,   16'h0300, 16'h7777, 16'h0000, 0);
        run_txn("rd_imm",    K_RD_IMM, 16'h0044, 16'h5A5A, 16'h0001, 1);
        run_txn("load_0ws",  K_RD,     16'hFFFF, 16'hC3C3, 16'h0000, 0);
        run_txn("load_last", K_RD,     16'h0011, 16'h0F0F, 16'h0000, TO - 1);
        run_txn("store_to",  K_WR,     16'h0022, 16'hAAAA, 16'h0000, TO);

        // Reset in the middle of a pending load.
        ps_bc_dm_rd  = 1'b1;
        ps_bc_dm_add = 16'h0abc;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
        end
        chk_val("midreq_req_before", 32'(bc_dm_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("midreq");
        ps_idle();
        exp_dt = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 30; i++) begin
            run_txn("rand", int'($urandom_range(0, 4)), AW'($urandom), DW'($urandom),
                    DW'($urandom), int'($urandom_range(0, TO + 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_connect.md
Name: bus_connect

Overview:
- Bridges the compute unit and data memory (DM) for load, store and immediate-load transfers issued by the program sequencer (PS).
- Upstream of the crossbar: drives bc_dt, the crossbar's bus-connect write data.
- Consumes crossbar X-port data (xb_dtx) as store data.
- Runs a request/acknowledge FSM to DM with a wait-state timeout, and stalls PS while a transfer is outstanding.

Parameters:
- RF_DATASIZE, 16, width of register-file data, bc_dt, and DM read/write data.
- DM_ADDR_WIDTH, 16, width of the DM address.
- TIMEOUT, 15, maximum number of REQ-state cycles spent waiting for dm_bc_ack before abort; must be at least 1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- ps_bc_dm_rd  input  1  load request: DM[ps_bc_dm_add] goes to bc_dt.
- ps_bc_dm_wr  input  1  store request: xb_dtx goes to DM[ps_bc_dm_add].
- ps_bc_dm_add  input  DM_ADDR_WIDTH  transfer address.
- ps_bc_imm_en  input  1  immediate-load request.
- ps_bc_imm  input  RF_DATASIZE  immediate value.
- xb_dtx  input  RF_DATASIZE  crossbar X-port data, used as store data.
- bc_dm_req  output  1  DM request, held until acknowledged or aborted.
- bc_dm_we  output  1  1 = write, 0 = read; valid while bc_dm_req is high.
- bc_dm_add  output  DM_ADDR_WIDTH  latched DM address.
- bc_dm_wdt  output  RF_DATASIZE  latched store data.
- dm_bc_rdt  input  RF_DATASIZE  DM read data; valid in the cycle dm_bc_ack is high.
- dm_bc_ack  input  1  DM acknowledge, single-cycle.
- bc_dt  output  RF_DATASIZE  data to the crossbar; holds its last value.
- bc_ps_dt_vld  output  1  one-cycle pulse: bc_dt is new; PS asserts ps_xb_w_bcEn in this cycle.
- bc_ps_stall  output  1  high while a DM transfer is outstanding.
- bc_ps_err  output  1  one-cycle error pulse.

Behaviour:
- States: IDLE, REQ, DONE.
- bc_ps_stall = (state != IDLE), decoded from the state register.
- Reset (asynchronous, effective immediately, including mid-transfer):
  - state = IDLE;
  - bc_dm_req, bc_dm_we, bc_ps_dt_vld, bc_ps_err = 0;
  - bc_dm_add, bc_dm_wdt, bc_dt = 0;
  - timeout counter = 0.
- IDLE, sampled at the clock edge:
  - rd=1 and wr=0: latch address, set we=0, go to REQ.
  - wr=1 and rd=0: latch address and xb_dtx, set we=1, go to REQ.
  - rd=1 and wr=1: no transfer; pulse bc_ps_err next cycle; stay in IDLE.
  - imm_en=1 with no rd/wr: bc_dt <= ps_bc_imm; bc_ps_dt_vld pulses next cycle; no stall.
  - imm_en together with rd or wr: the memory operation wins and the immediate is dropped.
- REQ:
  - bc_dm_req=1; address, we and wdt are stable.
  - The counter increments each cycle without dm_bc_ack.
  - ack on a read: bc_dt <= dm_bc_rdt; go to DONE.
  - ack on a write: go to IDLE.
  - In both cases bc_dm_req drops on the following cycle and the counter clears.
  - Counter reaches TIMEOUT without ack: drop bc_dm_req, pulse bc_ps_err, go to IDLE, leave bc_dt unchanged, clear the counter.
- DONE: bc_ps_dt_vld=1 for exactly this cycle; go to IDLE.
- Latency from request edge:
  - read with ack in the first REQ cycle: vld high 2 cycles after the request edge; stall high for 2 cycles;
  - write with ack in the first REQ cycle: stall high for 1 cycle;
  - immediate: vld high 1 cycle after the request edge.
- PS inputs are ignored outside IDLE; PS must hold them while stalled.
- dm_bc_ack outside REQ is ignored.
- A new request may be accepted in the same edge that returns the FSM to IDLE only from the next cycle onward; there are no back-to-back overlapping transfers.

Decomposition:
- Shared package contains:
  - state encodings (BC_IDLE=2'd0, BC_REQ=2'd1, BC_DONE=2'd2);
  - the default TIMEOUT constant;
  - the counter width, $clog2(TIMEOUT+1).
- One natural sub-module: bc_timeout_ctr, a loadable/clearable saturating counter with a terminal flag.
- The FSM and datapath registers live in bus_connect.

Test Plan:
- Reset mid-REQ: reset asserted while bc_dm_req=1 → bc_dm_req=0 and bc_ps_stall=0 with no clock edge; all outputs zero.
- Load with 3 wait states: rd=1, add=16'h0040; DM acks on the 4th REQ cycle with rdt=16'hBEEF → bc_dm_req high for 4 cycles, then bc_dt=16'hBEEF with bc_ps_dt_vld pulsed one cycle; stall high for 5 cycles.
- Store: wr=1, add=16'h0102, xb_dtx=16'h1234; DM acks on the 1st REQ cycle → bc_dm_we=1, bc_dm_wdt=16'h1234; no vld pulse; stall high for 1 cycle.
- Immediate: imm_en=1, imm=16'h00FF → bc_dt=16'h00FF and vld pulses 1 cycle later; stall never rises.
- Timeout: rd=1 with no ack, TIMEOUT=15 → req high for 15 cycles, then req=0, err pulses once, bc_dt keeps its prior value.
- Conflicts:
  - rd=1 and wr=1 → err pulse, bc_dm_req stays 0.
  - rd=1 with imm_en=1, imm=16'h0001 → load performed, immediate discarded.
